// File: rtl/seq_calculator.sv
// seq_calculator: clocked, handshaked successor to the 4-bit calculator; mul/div iterate one bit per cycle.
// Defining CALC_FLAGS_EN adds the registered zero/carry outputs.
module seq_calculator #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         oper,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out,
`ifdef CALC_FLAGS_EN
   output logic               zero,
   output logic               carry,
`endif
   output logic               err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]         state_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [2:0]         op_r;
   logic [2*WIDTH-1:0] work_r;
   logic [CW-1:0]      cnt_r;
   logic [2*WIDTH-1:0] out_r;
   logic               err_r;
   logic               out_valid_r;

   logic [WIDTH:0]     sum_s;
   logic [WIDTH:0]     diff_s;
   logic [2*WIDTH-1:0] res_s;
   logic               res_err_s;
   logic [2*WIDTH-1:0] iter_s;
   logic               b_zero_s;
   logic               long_op_s;

   // Shift-add step: upper half accumulates, lower half holds the remaining multiplier bits.
   function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] w,
                                                   input logic [WIDTH-1:0]   m);
      logic [WIDTH:0] s;
      s = {1'b0, w[2*WIDTH-1:WIDTH]} + (w[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      return {s, w[WIDTH-1:1]};
   endfunction

   // Restoring step: upper half is the partial remainder, lower half shifts dividend out / quotient in.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] w,
                                                   input logic [WIDTH-1:0]   d);
      logic [WIDTH:0] sh;
      logic [WIDTH:0] tr;
      sh = {w[2*WIDTH-1:WIDTH], w[WIDTH-1]};
      tr = sh - {1'b0, d};
      if (!tr[WIDTH]) begin
         return {tr[WIDTH-1:0], w[WIDTH-2:0], 1'b1};
      end else begin
         return {sh[WIDTH-1:0], w[WIDTH-2:0], 1'b0};
      end
   endfunction

   assign in_ready  = (state_r == IDLE);
   assign out_valid = out_valid_r;
   assign out       = out_r;
   assign err       = err_r;
   assign b_zero_s  = (b_r == {WIDTH{1'b0}});
   assign long_op_s = (oper == OP_MUL) || ((oper == OP_DIV) && (b != {WIDTH{1'b0}}));

   // Result selection from the captured operands and the iteration register.
   always_comb begin
      sum_s     = {1'b0, a_r} + {1'b0, b_r};
      diff_s    = {1'b0, a_r} - {1'b0, b_r};
      res_s     = {(2*WIDTH){1'b0}};
      res_err_s = 1'b0;
      case (op_r)
         OP_ADD: res_s = {{(WIDTH-1){1'b0}}, sum_s};
         OP_SUB: res_s = {{(WIDTH-1){diff_s[WIDTH]}}, diff_s};
         OP_MUL: res_s = work_r;
         OP_DIV: begin
            if (b_zero_s) begin
               res_s     = {a_r, {WIDTH{1'b1}}};
               res_err_s = 1'b1;
            end else begin
               res_s     = work_r;
               res_err_s = 1'b0;
            end
         end
         OP_AND:  res_s = {{WIDTH{1'b0}}, a_r & b_r};
         OP_OR:   res_s = {{WIDTH{1'b0}}, a_r | b_r};
         OP_XOR:  res_s = {{WIDTH{1'b0}}, a_r ^ b_r};
         OP_NOT:  res_s = {{WIDTH{1'b0}}, ~a_r};
         default: res_s = {(2*WIDTH){1'b0}};
      endcase
   end

   // Next value of the iteration register while in CALC.
   always_comb begin
      if (op_r == OP_MUL) begin
         iter_s = mul_step(work_r, a_r);
      end else begin
         iter_s = div_step(work_r, b_r);
      end
   end

`ifdef CALC_FLAGS_EN
   logic zero_r;
   logic carry_r;
   logic carry_s;

   assign zero  = zero_r;
   assign carry = carry_r;

   // Carry-out for add, borrow for sub, nothing otherwise.
   always_comb begin
      case (op_r)
         OP_ADD:  carry_s = sum_s[WIDTH];
         OP_SUB:  carry_s = diff_s[WIDTH];
         default: carry_s = 1'b0;
      endcase
   end

   // Flags are loaded on the same edge as out so they stay aligned under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_r  <= 1'b1;
         carry_r <= 1'b0;
      end else if ((state_r == DONE) && !out_valid_r) begin
         zero_r  <= (res_s == {(2*WIDTH){1'b0}});
         carry_r <= carry_s;
      end else begin
         zero_r  <= zero_r;
         carry_r <= carry_r;
      end
   end
`endif

   // Control FSM, operand capture, iteration and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         op_r        <= 3'b000;
         work_r      <= {(2*WIDTH){1'b0}};
         cnt_r       <= {CW{1'b0}};
         out_r       <= {(2*WIDTH){1'b0}};
         err_r       <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r     <= a;
                  b_r     <= b;
                  op_r    <= oper;
                  cnt_r   <= {CW{1'b0}};
                  work_r  <= {{WIDTH{1'b0}}, (oper == OP_MUL) ? b : a};
                  state_r <= long_op_s ? CALC : DONE;
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               work_r <= iter_s;
               cnt_r  <= cnt_r + CW'(1);
               if (cnt_r == CNT_LAST) begin
                  state_r <= DONE;
               end else begin
                  state_r <= CALC;
               end
            end
            DONE: begin
               // First DONE cycle registers the result; afterwards hold until the sink takes it.
               if (!out_valid_r) begin
                  out_r       <= res_s;
                  err_r       <= res_err_s;
                  out_valid_r <= 1'b1;
               end else if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_calculator.sv
// Directed bench for seq_calculator: WIDTH=4 instance checked every cycle against an arithmetic model,
// plus a WIDTH=8 instance checked against hand-computed literals.
module tb_seq_calculator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       in_valid, in_ready;
   logic [3:0] a, b;
   logic [2:0] oper;
   logic       out_valid, out_ready;
   logic [7:0] out;
   logic       err;
`ifdef CALC_FLAGS_EN
   logic       zero, carry;
`endif

   logic        in_valid8, in_ready8;
   logic [7:0]  a8, b8;
   logic [2:0]  oper8;
   logic        out_valid8, out_ready8;
   logic [15:0] out8;
   logic        err8;
`ifdef CALC_FLAGS_EN
   logic        zero8, carry8;
`endif

   seq_calculator #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .oper(oper), .out_valid(out_valid), .out_ready(out_ready),
      .out(out),
`ifdef CALC_FLAGS_EN
      .zero(zero), .carry(carry),
`endif
      .err(err)
   );

   seq_calculator #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .oper(oper8), .out_valid(out_valid8), .out_ready(out_ready8),
      .out(out8),
`ifdef CALC_FLAGS_EN
      .zero(zero8), .carry(carry8),
`endif
      .err(err8)
   );

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      fails++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // Model of the 4-bit calculator from the opcode table, using plain integer arithmetic.
   function automatic void model(input int ai, input int bi, input int op,
                                 output logic [7:0] o, output logic e, output logic c,
                                 output int lat);
      e = 1'b0; c = 1'b0; lat = 1;
      case (op)
         0: begin o = 8'(ai + bi); c = (ai + bi) > 15; end
         1: begin o = 8'(ai - bi); c = ai < bi; end
         2: begin o = 8'(ai * bi); lat = 5; end
         3: begin
            if (bi == 0) begin o = 8'(ai * 16 + 15); e = 1'b1; end
            else begin o = 8'((ai % bi) * 16 + ai / bi); lat = 5; end
         end
         4: o = 8'(ai & bi);
         5: o = 8'(ai | bi);
         6: o = 8'(ai ^ bi);
         7: o = 8'(15 - ai);
         default: o = 8'h00;
      endcase
   endfunction

   bit         pend   = 1'b0;
   bit         chk_en = 1'b0;
   bit         seen;
   int         k;
   int         exp_lat;
   logic [7:0] exp_o;
   logic       exp_e, exp_c;
   logic [7:0] last_o;

   always @(posedge clk) if (pend) k = k + 1;

   // Single compare process: every negedge, the WIDTH=4 outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         if (pend) begin
            if (out_valid) begin
               if (!seen) begin
                  chk("latency", k, exp_lat);
                  seen = 1'b1;
               end
               chk("out", out, exp_o);
               chk("err", err, exp_e);
`ifdef CALC_FLAGS_EN
               chk("zero", zero, exp_o == 8'h00);
               chk("carry", carry, exp_c);
`endif
               chk("in_ready_done", in_ready, 1'b0);
               if (out_ready) begin
                  last_o = out;
                  pend   = 1'b0;
               end
            end else begin
               chk("in_ready_busy", in_ready, 1'b0);
            end
         end else begin
            chk("idle_out_valid", out_valid, 1'b0);
            chk("idle_in_ready", in_ready, 1'b1);
         end
      end
   end

   task automatic issue(input int ai, input int bi, input int op);
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) fail_now("accept_wait");
      a = 4'(ai); b = 4'(bi); oper = 3'(op); in_valid = 1'b1;
      model(ai, bi, op, exp_o, exp_e, exp_c, exp_lat);
      @(posedge clk); #1;
      in_valid = 1'b0;
      k = 0; seen = 1'b0; pend = 1'b1;
      a = 4'(~ai); b = 4'(bi + 5); oper = 3'(op + 3);
   endtask

   task automatic finish_wait();
      int n = 0;
      while (pend && n < 60) begin @(posedge clk); #1; n++; end
      if (pend) begin
         fail_now("result_wait");
         pend = 1'b0;
      end
   endtask

   task automatic run(input int ai, input int bi, input int op, input logic [7:0] lit);
      issue(ai, bi, op);
      finish_wait();
      chk("literal", last_o, lit);
   endtask

   task automatic run8(input int ai, input int bi, input int op, input logic [15:0] lit,
                       input logic e, input logic c, input int lat);
      int n = 0;
      while (in_ready8 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      a8 = 8'(ai); b8 = 8'(bi); oper8 = 3'(op); in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      n = 0;
      while (out_valid8 !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
      chk("w8_latency", n, lat);
      chk("w8_out", out8, lit);
      chk("w8_err", err8, e);
`ifdef CALC_FLAGS_EN
      chk("w8_zero", zero8, lit == 16'h0000);
      chk("w8_carry", carry8, c);
`else
      if (c !== 1'b0 && c !== 1'b1) $display("carry expectation undefined");
`endif
      @(posedge clk); #1;
      chk("w8_consumed", out_valid8, 1'b0);
   endtask

   logic [7:0] lits [8] = '{8'h0C, 8'h06, 8'h1B, 8'h03, 8'h01, 8'h0B, 8'h0A, 8'h06};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = 4'd0; b = 4'd0; oper = 3'd0; out_ready = 1'b1;
      in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0; oper8 = 3'd0; out_ready8 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out", out, 8'h00);
      chk("rst_err", err, 1'b0);
`ifdef CALC_FLAGS_EN
      chk("rst_zero", zero, 1'b1);
      chk("rst_carry", carry, 1'b0);
`endif
      rst = 1'b0;
      chk_en = 1'b1;

      for (int i = 0; i < 8; i++) run(9, 3, i, lits[i]);

      run(15, 15, 2, 8'hE1);
      run(7, 8, 0, 8'h0F);
      run(15, 1, 0, 8'h10);
      run(5, 5, 1, 8'h00);
      run(3, 9, 1, 8'hFA);
      run(13, 0, 3, 8'hDF);
      run(13, 4, 3, 8'h13);

      // Backpressure: result held for 10 cycles while new commands are offered.
      out_ready = 1'b0;
      issue(6, 7, 2);
      begin
         int n = 0;
         while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
         if (n >= 20) fail_now("bp_valid_wait");
      end
      for (int i = 0; i < 10; i++) begin
         in_valid = (i >= 2 && i < 6);
         a = 4'd1; b = 4'd2; oper = 3'd0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      finish_wait();
      chk("bp_literal", last_o, 8'h2A);
      @(posedge clk); #1;

      // Reset during the second CALC cycle of a multiply.
      issue(15, 15, 2);
      @(posedge clk); #1;
      rst = 1'b1; chk_en = 1'b0; pend = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mrst_in_ready", in_ready, 1'b1);
      chk("mrst_out_valid", out_valid, 1'b0);
      chk("mrst_out", out, 8'h00);
      chk("mrst_err", err, 1'b0);
      chk_en = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      run(5, 6, 0, 8'h0B);

      run8(200, 7, 2, 16'h0578, 1'b0, 1'b0, 9);
      run8(200, 7, 3, 16'h041C, 1'b0, 1'b0, 9);
      run8(200, 0, 3, 16'hC8FF, 1'b1, 1'b0, 1);
      run8(200, 100, 0, 16'h012C, 1'b0, 1'b1, 1);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
- Parametrised, clocked successor to the combinational 4-bit `calculator`.
- Keeps the same 3-bit opcode set, widened to WIDTH-bit operands and a 2*WIDTH-bit result.
- Multiply and divide are iterative (multi-cycle).
- Valid/ready handshakes on both input and output, so it can sit between a stimulus/command source and a result sink, with a divide-by-zero error flag.

Parameters:
- WIDTH, 4, operand width in bits (≥2); result width is 2*WIDTH.

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  block can accept a command.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- oper  input  3  opcode.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- out  output  2*WIDTH  result.
- err  output  1  divide-by-zero flag, qualified by out_valid.
- zero  output  1  [CALC_FLAGS_EN only] result == 0.
- carry  output  1  [CALC_FLAGS_EN only] add carry-out / sub borrow.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - state=IDLE, in_ready=1, out_valid=0, out=0, err=0, counter=0; zero=1 and carry=0 when flags are enabled.
  - rst overrides every other input. An op in progress is abandoned and no result is ever presented for it.
- States: IDLE, CALC, DONE.
- in_ready is 1 only in IDLE (registered/state-decoded). Nothing is accepted in CALC or DONE, and in_valid there is ignored.
- Accept: in_valid & in_ready at edge t. a, b and oper are captured into internal registers; later input changes have no effect.
- Opcodes (all unsigned, result zero-extended to 2*WIDTH unless stated):
  - 000 add: a+b.
  - 001 sub: (a−b) computed at WIDTH+1 bits, then sign-extended to 2*WIDTH (two's complement).
  - 010 mul: a*b, shift-add, one partial product per cycle.
  - 011 div: restoring division. out = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
  - 100 and: a&b.
  - 101 or: a|b.
  - 110 xor: a^b.
  - 111 not: ~a (WIDTH bits, then zero-extended).
- Single-cycle ops (000, 001, 100–111, and div with b==0): IDLE→DONE. out_valid=1 at edge t+1.
- mul, and div with b≠0: IDLE→CALC. The counter runs WIDTH cycles, then CALC→DONE. out_valid=1 at edge t+WIDTH+1.
- Divide by zero: no iteration. quotient=all ones, remainder=a, err=1. err=0 for every other case.
- DONE:
  - out, err and flags are held stable while out_valid=1 & out_ready=0 (backpressure of any length).
  - On out_valid & out_ready at edge u: out_valid=0 and state=IDLE at u; in_ready=1 from u.
  - out keeps its last value after the handshake.
- Throughput: one command per (latency + 1) cycles minimum. There is no overlap of accept and result handshake.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro CALC_FLAGS_EN.
- Defined:
  - Ports zero and carry exist and are registered together with out.
  - zero = (out == 0).
  - carry = carry-out of the WIDTH-bit add for 000, borrow (a<b) for 001, 0 for all other ops.
  - Reset values: zero=1, carry=0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, a=4'b1001, b=4'b0011, oper stepped 000→111, one command per handshake, out_ready=1 → out = 8'h0C, 8'h06, 8'h1B, 8'h03, 8'h01, 8'h0B, 8'h0A, 8'h06; err=0 throughout.
- Latency check, WIDTH=4 → add: out_valid one cycle after accept; mul a=15 b=15: out_valid five cycles after accept, out=8'hE1; in_ready=0 for the whole busy period.
- Sub and div edge cases → a=3 b=9 sub gives out=8'hFA (carry=1 if CALC_FLAGS_EN); a=13 b=0 div gives out=8'hDF, err=1, one-cycle latency; a=13 b=4 div gives out=8'h13.
- Backpressure → hold out_ready=0 for 10 cycles after out_valid. Out stays stable; in_valid pulses with new operands during this window are not accepted. The result is consumed when out_ready rises, and in_ready is 1 the following cycle.
- Reset mid-operation → assert rst on the 2nd CALC cycle of a mul. Next cycle: IDLE, in_ready=1, out_valid=0, out=0. The abandoned result never appears; a subsequent add 5+6 returns 8'h0B.
- WIDTH=8 regression → a=200 b=7: mul gives 16'h0578; div gives out={8'd4, 8'd28}=16'h041C.
